// File: rtl/brick_field.sv
// Brick layer for the breakout game: ten-brick row with ball hit detection,
// hit lockout, level-clear/refill sequencing and the brick pixel colour.
module brick_field #(
  parameter logic [9:0]  BRICK_Y    = 10'd40,
  parameter logic [9:0]  BRICK_W    = 10'd60,
  parameter logic [9:0]  BRICK_H    = 10'd20,
  parameter logic [9:0]  PITCH      = 10'd64,
  parameter logic [19:0] LOCKOUT    = 20'd416667,
  parameter logic [23:0] CLEAR_HOLD = 24'd6000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        active_pixels,
  input  logic [9:0]  ball_x,
  input  logic [9:0]  ball_y,
  input  logic [9:0]  ball_width,
  input  logic [9:0]  ball_height,
  output logic [9:0]  collide,
  output logic [9:0]  block_x,
  output logic [9:0]  block_y,
  output logic [9:0]  block_width,
  output logic [9:0]  block_height,
  output logic [9:0]  alive,
  output logic [15:0] score,
  output logic        level_clear,
  output logic [23:0] vga_color
);

  typedef enum logic [1:0] {RUN = 2'd0, CLEAR = 2'd1, REFILL = 2'd2} state_t;

  state_t       state_r;
  logic [19:0]  lock_r;
  logic [23:0]  clr_r;
  logic [10:0]  lx_s [10];
  logic [9:0]   overlap_s;
  logic [9:0]   cand_s;
  logic [3:0]   hit_idx_s;
  logic         hit_s;

  // Brick geometry, ball overlap (11-bit sums, no wrap) and lowest-index selection.
  always_comb begin
    overlap_s = 10'd0;
    for (int i = 0; i < 10; i++) begin
      lx_s[i] = 11'(i) * {1'b0, PITCH};
      overlap_s[i] = ({1'b0, ball_x} < lx_s[i] + {1'b0, BRICK_W}) &&
                     ({1'b0, ball_x} + {1'b0, ball_width} > lx_s[i]) &&
                     ({1'b0, ball_y} < {1'b0, BRICK_Y} + {1'b0, BRICK_H}) &&
                     ({1'b0, ball_y} + {1'b0, ball_height} > {1'b0, BRICK_Y});
    end
    cand_s    = overlap_s & alive;
    hit_idx_s = 4'd0;
    for (int i = 9; i >= 0; i--) begin
      hit_idx_s = cand_s[i] ? 4'(i) : hit_idx_s;
    end
    hit_s = (state_r == RUN) && (lock_r == 20'd0) && (cand_s != 10'd0);
  end

  // Game state: hits, lockout, clear hold and refill.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= RUN;
      alive        <= 10'h3FF;
      collide      <= 10'd0;
      score        <= 16'd0;
      level_clear  <= 1'b0;
      lock_r       <= 20'd0;
      clr_r        <= 24'd0;
      block_x      <= 10'd0;
      block_y      <= BRICK_Y;
      block_width  <= BRICK_W;
      block_height <= BRICK_H;
    end else begin
      collide <= 10'd0;
      lock_r  <= (lock_r != 20'd0) ? lock_r - 20'd1 : 20'd0;
      case (state_r)
        RUN: begin
          if (hit_s) begin
            collide      <= 10'd1 << hit_idx_s;
            alive        <= alive & ~(10'd1 << hit_idx_s);
            block_x      <= lx_s[hit_idx_s][9:0];
            block_y      <= BRICK_Y;
            block_width  <= BRICK_W;
            block_height <= BRICK_H;
            score        <= (score != 16'hFFFF) ? score + 16'd1 : score;
            lock_r       <= LOCKOUT;
          end else if (alive == 10'd0) begin
            state_r     <= CLEAR;
            clr_r       <= CLEAR_HOLD;
            level_clear <= 1'b1;
          end else begin
            state_r <= RUN;
          end
        end
        CLEAR: begin
          // Leaving when the count would reach zero keeps CLEAR exactly CLEAR_HOLD cycles long.
          if (clr_r <= 24'd1) begin
            state_r     <= REFILL;
            clr_r       <= 24'd0;
            level_clear <= 1'b0;
          end else begin
            clr_r <= clr_r - 24'd1;
          end
        end
        REFILL: begin
          alive   <= 10'h3FF;
          lock_r  <= LOCKOUT;
          state_r <= RUN;
        end
        default: begin
          state_r     <= RUN;
          level_clear <= 1'b0;
        end
      endcase
    end
  end

  // Brick pixel colour: red for even bricks, orange for odd, black elsewhere.
  always_comb begin
    vga_color = 24'h000000;
    for (int i = 0; i < 10; i++) begin
      vga_color = (active_pixels && alive[i] &&
                   ({1'b0, x} >= lx_s[i]) && ({1'b0, x} < lx_s[i] + {1'b0, BRICK_W}) &&
                   (y >= BRICK_Y) && ({1'b0, y} < {1'b0, BRICK_Y} + {1'b0, BRICK_H}))
                  ? ((i % 2 == 1) ? 24'hFF8000 : 24'hFF0000) : vga_color;
    end
  end

endmodule

// File: tb/tb_brick_field.sv
// Bench for brick_field: behavioural game model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_brick_field;
  localparam int LOCK = 4;
  localparam int CH   = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  x = 10'd0, y = 10'd0;
  logic        active_pixels = 1'b0;
  logic [9:0]  ball_x = 10'd0, ball_y = 10'd400, ball_width = 10'd10, ball_height = 10'd10;
  logic [9:0]  collide, block_x, block_y, block_width, block_height, alive;
  logic [15:0] score;
  logic        level_clear;
  logic [23:0] vga_color;

  int n_vec = 0;
  int n_err = 0;

  brick_field #(.LOCKOUT(20'd4), .CLEAR_HOLD(24'd6)) dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .active_pixels(active_pixels),
    .ball_x(ball_x), .ball_y(ball_y), .ball_width(ball_width), .ball_height(ball_height),
    .collide(collide), .block_x(block_x), .block_y(block_y), .block_width(block_width),
    .block_height(block_height), .alive(alive), .score(score),
    .level_clear(level_clear), .vga_color(vga_color)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: time-stamped lockout and clear windows.
  int          cyc = 0, next_ok = 0, clear_end = 0, m_phase = 0;
  logic [9:0]  m_alive = 10'h3FF, m_collide = 10'd0;
  logic [15:0] m_score = 16'd0;
  int          m_bx = 0;
  bit          model_on = 0;

  function automatic bit ov(int i);
    int bx, by, bw, bh;
    bx = ball_x; by = ball_y; bw = ball_width; bh = ball_height;
    return (bx < i*64 + 60) && (bx + bw > i*64) && (by < 60) && (by + bh > 40);
  endfunction

  function automatic logic [23:0] colour(int xx, int yy, logic [9:0] al);
    int i;
    i = xx / 64;
    if (yy < 40 || yy >= 60 || i > 9 || (xx % 64) >= 60 || !al[i]) return 24'h000000;
    return (i % 2 == 1) ? 24'hFF8000 : 24'hFF0000;
  endfunction

  task automatic m_reset();
    m_phase = 0; m_alive = 10'h3FF; m_collide = 10'd0; m_score = 16'd0;
    m_bx = 0; next_ok = 0; model_on = 1;
  endtask

  task automatic check_all();
    chk("collide", 32'(collide), 32'(m_collide));
    chk("alive", 32'(alive), 32'(m_alive));
    chk("score", 32'(score), 32'(m_score));
    chk("level_clear", 32'(level_clear), 32'(m_phase == 1));
    chk("block_x", 32'(block_x), 32'(m_bx));
    chk("block_y", 32'(block_y), 32'd40);
    chk("block_w", 32'(block_width), 32'd60);
    chk("block_h", 32'(block_height), 32'd20);
  endtask

  // Model step on every edge, then compare shortly after.
  always @(posedge clk) begin
    if (rst && model_on) begin
      int hit;
      cyc++;
      m_collide = 10'd0;
      case (m_phase)
        0: begin
          hit = -1;
          for (int i = 0; i < 10; i++) if (hit < 0 && m_alive[i] && ov(i)) hit = i;
          if (hit >= 0 && cyc >= next_ok) begin
            m_collide = 10'd1 << hit;
            m_alive[hit] = 1'b0;
            m_bx = hit * 64;
            if (m_score != 16'hFFFF) m_score = m_score + 16'd1;
            next_ok = cyc + LOCK + 1;
          end else if (m_alive == 10'd0) begin
            m_phase = 1;
            clear_end = cyc + CH;
          end
        end
        1: if (cyc >= clear_end) m_phase = 2;
        default: begin
          m_alive = 10'h3FF;
          next_ok = cyc + LOCK + 1;
          m_phase = 0;
        end
      endcase
      #1;
      check_all();
    end
  end

  task automatic ball_away();
    ball_x = 10'd0; ball_y = 10'd400; ball_width = 10'd10; ball_height = 10'd10;
  endtask

  task automatic hit_brick(input int i);
    bit seen;
    @(negedge clk);
    ball_x = 10'(i*64 + 20); ball_y = 10'd45; ball_width = 10'd20; ball_height = 10'd20;
    seen = 0;
    for (int k = 0; k < LOCK + 4; k++) begin
      @(posedge clk); #2;
      if (collide != 10'd0) begin
        seen = 1;
        break;
      end
    end
    if (seen) chk("hit_sel", 32'(collide), 32'(10'd1 << i));
    else begin
      n_vec++; n_err++;
      $display("FAIL hit_timeout: brick %0d got no collide, expected a pulse", i);
    end
    @(negedge clk);
    ball_away();
  endtask

  initial begin
    int cnt;
    #1 rst = 1'b0;
    m_reset();
    #1;
    check_all();
    chk("rst_alive", 32'(alive), 32'h3FF);
    chk("rst_block_y", 32'(block_y), 32'd40);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    // Pixel scan, all bricks alive.
    active_pixels = 1'b1; y = 10'd50;
    x = 10'd59;  #1 chk("vga_x59", 32'(vga_color), 32'hFF0000);
    x = 10'd60;  #1 chk("vga_x60", 32'(vga_color), 32'h000000);
    x = 10'd64;  #1 chk("vga_x64", 32'(vga_color), 32'hFF8000);
    x = 10'd127; #1 chk("vga_x127", 32'(vga_color), 32'h000000);
    active_pixels = 1'b0; x = 10'd10; #1 chk("vga_inactive", 32'(vga_color), 32'h000000);
    active_pixels = 1'b1;
    for (int yy = 35; yy < 66; yy += 6) begin
      for (int xx = 0; xx < 640; xx += 23) begin
        x = 10'(xx); y = 10'(yy); #1;
        chk("vga_sweep", 32'(vga_color), 32'(colour(xx, yy, m_alive)));
      end
    end
    active_pixels = 1'b0;

    // Single hit on brick 1.
    @(negedge clk);
    ball_x = 10'd100; ball_y = 10'd45; ball_width = 10'd20; ball_height = 10'd20;
    @(posedge clk); #2;
    chk("t42_collide", 32'(collide), 32'h002);
    chk("t42_alive", 32'(alive), 32'h3FD);
    chk("t42_block_x", 32'(block_x), 32'd64);
    chk("t42_score", 32'(score), 32'd1);
    @(negedge clk);
    ball_away();
    @(posedge clk); #2;
    chk("t42_pulse_end", 32'(collide), 32'h000);

    // Reset mid-lockout.
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b1;

    // Two overlapped bricks: lowest first, the other after the lockout.
    @(negedge clk);
    ball_x = 10'd50; ball_y = 10'd45; ball_width = 10'd20; ball_height = 10'd20;
    @(posedge clk); #2;
    chk("t43_first", 32'(collide), 32'h001);
    chk("t43_alive", 32'(alive), 32'h3FE);
    for (int k = 1; k <= LOCK + 1; k++) begin
      @(posedge clk); #2;
    end
    chk("t43_second", 32'(collide), 32'h002);

    // Ball parked on a dead brick.
    @(negedge clk);
    ball_x = 10'd100;
    repeat (8) @(posedge clk);
    #2;
    chk("t44_score", 32'(score), 32'd2);
    chk("t44_collide", 32'(collide), 32'h000);
    @(negedge clk);
    ball_away();

    // Clear the level and time the CLEAR window.
    for (int i = 2; i < 10; i++) hit_brick(i);
    chk("t45_score", 32'(score), 32'd10);
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #2;
      if (level_clear) cnt++;
      if (cnt > 0 && !level_clear) break;
    end
    chk("t45_clear_len", 32'(cnt), 32'(CH));
    @(posedge clk); #2;
    chk("t45_refill", 32'(alive), 32'h3FF);
    chk("t45_lc_low", 32'(level_clear), 32'd0);
    chk("t45_score_kept", 32'(score), 32'd10);

    // Clear again and reset during CLEAR.
    for (int i = 0; i < 10; i++) hit_brick(i);
    repeat (3) @(posedge clk);
    #2;
    chk("t46_in_clear", 32'(level_clear), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    #1;
    chk("t46_alive", 32'(alive), 32'h3FF);
    chk("t46_score", 32'(score), 32'd0);
    chk("t46_lc", 32'(level_clear), 32'd0);
    check_all();
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule

// File: doc/brick_field.md
BRICK_FIELD -- requirements
Module: brick_field

Interface
REQ-001 Parameter BRICK_Y, default 10'd40, top edge of the brick row in pixels.
REQ-002 Parameter BRICK_W, default 10'd60, brick width in pixels.
REQ-003 Parameter BRICK_H, default 10'd20, brick height in pixels.
REQ-004 Parameter PITCH, default 10'd64, horizontal distance between left edges of adjacent bricks; brick i left edge = i*PITCH, i = 0..9.
REQ-005 Parameter LOCKOUT, default 20'd416667, number of cycles after a hit during which new hits are ignored.
REQ-006 Parameter CLEAR_HOLD, default 24'd6000000, number of cycles the CLEAR state lasts.
REQ-007 clk  in  1  clock.
REQ-008 rst  in  1  reset, asynchronous, active-low.
REQ-009 x, y  in  10 each  current VGA pixel coordinate.
REQ-010 active_pixels  in  1  high inside the visible 640x480 area.
REQ-011 ball_x, ball_y, ball_width, ball_height  in  10 each  ball rectangle from the ball stage.
REQ-012 collide  out  10  one-cycle hit pulse per brick; bit0 drives collide_block, bits1..9 drive collide_block2..collide_block10.
REQ-013 block_x, block_y, block_width, block_height  out  10 each  geometry of the most recently hit brick.
REQ-014 alive  out  10  brick-present mask, bit i = brick i.
REQ-015 score  out  16  count of bricks destroyed.
REQ-016 level_clear  out  1  high while in the CLEAR state.
REQ-017 vga_color  out  24  brick-layer pixel colour, RGB 8:8:8.

Function
REQ-018 The block SHALL implement FSM states RUN, CLEAR, and REFILL.
REQ-019 overlap[i] SHALL be true when ball_x < Lx+BRICK_W, ball_x+ball_width > Lx, ball_y < BRICK_Y+BRICK_H, and ball_y+ball_height > BRICK_Y, where Lx = i*PITCH; all sums SHALL be evaluated at 11 bits, with no wrap.
REQ-020 In RUN, when lockout counter = 0 and (overlap & alive) is nonzero, the block SHALL select the lowest index i.
REQ-021 For the selected brick, on the next edge the block SHALL: set collide = (1<<i) for exactly one cycle, clear alive[i], and load block_x=i*PITCH, block_y=BRICK_Y, block_width=BRICK_W, block_height=BRICK_H.
REQ-022 On the same edge the block SHALL increment score, saturating at 16'hFFFF, and load the lockout counter with LOCKOUT.
REQ-023 Detect-to-pulse latency SHALL be exactly 1 clock.
REQ-024 Only one brick SHALL be destroyed per hit event.
REQ-025 The lockout counter SHALL decrement by 1 each cycle while it is nonzero; while nonzero, overlaps SHALL be ignored, with alive unchanged and collide = 0.
REQ-026 Other overlapped bricks SHALL be untouched and may be hit after the lockout expires.
REQ-027 collide SHALL be 0 on every cycle that is not a hit edge.
REQ-028 block_* outputs SHALL hold their value until the next hit.
REQ-029 In RUN, when alive == 0, the FSM SHALL go to CLEAR on the next edge and load the clear counter with CLEAR_HOLD.
REQ-030 The transition to CLEAR SHALL occur on the edge after the hit that cleared the last brick.
REQ-031 In CLEAR, level_clear SHALL be 1, no hits SHALL be generated, and the clear counter SHALL decrement each cycle.
REQ-032 When the clear counter reaches 0, the FSM SHALL go to REFILL.
REQ-033 REFILL SHALL last one cycle, set alive = 10'h3FF and lockout = LOCKOUT, and then return to RUN; score SHALL be retained.
REQ-034 vga_color SHALL be combinational.
REQ-035 vga_color SHALL be 0 when active_pixels = 0.
REQ-036 When active_pixels = 1 and pixel (x,y) lies inside alive brick i, vga_color SHALL be 24'hFF0000 for even i and 24'hFF8000 for odd i.
REQ-037 vga_color SHALL be 0 for all other pixels, including the 4-pixel gaps between bricks.
REQ-038 Overlap/hit logic SHALL run every clock and SHALL NOT be tied to the ball's 60 Hz move tick.

Reset
REQ-039 On rst low, regardless of state, the block SHALL immediately set: state=RUN, alive=10'h3FF, collide=0, score=0, level_clear=0, lockout=0, clear counter=0, block_x=0, block_y=BRICK_Y, block_width=BRICK_W, block_height=BRICK_H.
REQ-040 After rst is released, the block SHALL resume normal operation from the first clk rising edge.
REQ-041 Reset asserted in CLEAR or mid-lockout SHALL abort that state with no residual pulse.

Verification
REQ-042 Ball (100,45,20,20), all alive -> collide=10'b0000000010 for one cycle, alive=10'h3FD, block_x=64, score=1.
REQ-043 Ball (50,45,20,20), overlapping bricks 0 and 1 -> only bit0 pulses, alive=10'h3FE; brick 1 is hit after LOCKOUT+1 cycles if overlap persists.
REQ-044 Ball held on a dead brick's area -> collide stays 0 and score is unchanged.
REQ-045 Destroy all 10 bricks -> score=10, level_clear=1 for CLEAR_HOLD cycles, then alive=10'h3FF and level_clear=0, with score still 10.
REQ-046 Assert rst during CLEAR -> alive=10'h3FF, score=0, level_clear=0 immediately.
REQ-047 Pixel scan at y=50 with x=59, 60, 64, 127 and active_pixels=1, all alive -> vga_color = FF0000, 000000, FF8000, 000000.
